memory_unit: RTL and testbench
==============================

Name: memory_unit

Overview:
- Byte-addressed, word-accessed main-memory model for the MIPS processor; holds program image and data starting at 0x80020000.
- Supports single-word and fixed-length burst reads/writes on a 32-bit bus, with registered read data and a busy indication during bursts.
- Sits between the fetch/load-store stages and is preloaded by the bench through its normal write port.

Parameters:
- data_width, 32, word width in bits.
- address_width, 32, address bus width.
- depth, 1048576, storage size in bytes.
- start_addr, 32'h80020000, byte address mapped to storage offset 0.

Ports:
- clock  in  1  single clock; all state changes on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- address  in  address_width  byte address of first word; bits [1:0] ignored (word aligned).
- data_in  in  data_width  write data.
- access_size  in  2  00=1 word, 01=4 words, 10=8 words, 11=16 words.
- rw  in  1  0=write, 1=read.
- enable  in  1  request valid.
- busy  out  2  [0]=burst in progress (more beats follow), [1]=address-error pulse.
- data_out  out  data_width  registered read data.

Behaviour:
- Reset (reset_n low at posedge): data_out=0, busy=0, burst FSM to IDLE; array contents are not cleared.
- Mapping: offset = address - start_addr, low 2 bits forced 0; in range iff offset+3 < depth. Storage big-endian: byte offset holds data[31:24], offset+3 holds data[7:0].
- FSM states IDLE, BURST. IDLE + enable at posedge: accept request, latch rw, word address, beat count = 1/4/8/16 from access_size.
- Write beat: at the posedge, data_in written to current word; address advances by 4 for the next beat.
- Read beat: at the posedge, current word loaded into data_out (valid after that edge, 1-cycle latency); data_out holds its value when no read beat occurs.
- Count >1: go to BURST after first beat, busy[0]=1; each later posedge with enable=1 performs next beat on sequential address; address/rw/access_size inputs ignored during BURST. busy[0] drops after the edge that performs the final beat, FSM back to IDLE.
- enable=0 during BURST: burst aborted at that edge, IDLE, busy[0]=0, no access.
- Out-of-range beat: write suppressed, read loads data_out=0, busy[1]=1 for one cycle; burst continues counting.
- Address wraps modulo 2^32 when incrementing; range check applied per beat.
- Read and write never both occur in one cycle; reset wins over any request.
- enable=0 in IDLE: no state change.

Decomposition:
- Shared package mem_pkg: access_size encodings (ACC_1W, ACC_4W, ACC_8W, ACC_16W), MEM_START_ADDR, RW_WRITE/RW_READ constants, beat-count function.
- Single module; burst counter/FSM inline (no sub-module needed).

Test Plan:
- Reset: reset_n=0 for 2 cycles -> data_out=0, busy=2'b00.
- Single write/read: write 0x27BDFFE8 at 0x80020000, then read same address -> data_out=0x27BDFFE8 one cycle after read edge; write 0x11223344 at 0x80020004, read 0x80020006 -> 0x11223344 (alignment).
- Sequential preload: write 8 words 0x0..0x7 at 0x80020000+4k, read back -> each word matches, in order.
- 4-word burst: write burst of 0xA0..0xA3 at 0x80020100 with access_size=01 -> busy[0]=1 for 3 cycles; read burst -> data_out 0xA0,0xA1,0xA2,0xA3 on consecutive cycles.
- Abort: 16-word read, drop enable after 5 beats -> busy=0 next cycle, FSM idle, new single read served normally.
- Out of range: read 0x80000000 -> data_out=0, busy[1] pulses once; write 0x80120000 -> no array change.

Source files
------------

// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_pkg
// Description : Shared constants and helpers for the MIPS main-memory model.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_pkg;

    localparam logic [1:0]  ACC_1W         = 2'b00;
    localparam logic [1:0]  ACC_4W         = 2'b01;
    localparam logic [1:0]  ACC_8W         = 2'b10;
    localparam logic [1:0]  ACC_16W        = 2'b11;

    localparam logic [31:0] MEM_START_ADDR = 32'h8002_0000;

    localparam logic        RW_WRITE       = 1'b0;
    localparam logic        RW_READ        = 1'b1;

    function automatic logic [4:0] beat_count(input logic [1:0] acc);
        case (acc)
            ACC_1W:  beat_count = 5'd1;
            ACC_4W:  beat_count = 5'd4;
            ACC_8W:  beat_count = 5'd8;
            default: beat_count = 5'd16;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/memory_unit.sv
`default_nettype none
// ============================================================================
// Module      : memory_unit
// Description : Word-accessed, byte-addressed main memory with burst support.
// Revision    : 1.0 - initial release
// ============================================================================
module memory_unit
    import mem_pkg::*;
#(
    parameter int          DATA_WIDTH    = 32,
    parameter int          ADDRESS_WIDTH = 32,
    parameter int          DEPTH         = 1048576,
    parameter logic [31:0] START_ADDR    = MEM_START_ADDR
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic [ADDRESS_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0]    data_in,
    input  logic [1:0]               access_size,
    input  logic                     rw,
    input  logic                     enable,
    output logic [1:0]               busy,
    output logic [DATA_WIDTH-1:0]    data_out
);

    localparam int                     c_WORDS = DEPTH / 4;
    localparam int                     c_IDX_W = $clog2(c_WORDS);
    localparam logic [ADDRESS_WIDTH:0] c_DEPTH = (ADDRESS_WIDTH+1)'(DEPTH);

    localparam logic [0:0] c_IDLE  = 1'b0;
    localparam logic [0:0] c_BURST = 1'b1;

    logic [DATA_WIDTH-1:0]    r_mem [c_WORDS];
    logic [0:0]               r_state;
    logic [ADDRESS_WIDTH-1:0] r_addr;
    logic                     r_rw;
    logic [4:0]               r_left;
    logic                     r_err;
    logic [DATA_WIDTH-1:0]    r_data_out;

    logic                     w_beat;
    logic                     w_beat_rw;
    logic [ADDRESS_WIDTH-1:0] w_beat_addr;
    logic [ADDRESS_WIDTH-1:0] w_offset;
    logic                     w_in_range;
    logic [c_IDX_W-1:0]       w_idx;
    logic [4:0]               w_count;

    // In IDLE the beat uses the live request; inside a burst the latched one.
    assign w_beat      = enable;
    assign w_beat_addr = (r_state == c_IDLE) ? (address & ~(ADDRESS_WIDTH'(3))) : r_addr;
    assign w_beat_rw   = (r_state == c_IDLE) ? rw : r_rw;
    assign w_offset    = w_beat_addr - ADDRESS_WIDTH'(START_ADDR);
    assign w_in_range  = ({1'b0, w_offset} + (ADDRESS_WIDTH+1)'(3)) < c_DEPTH;
    assign w_idx       = w_offset[c_IDX_W+1:2];
    assign w_count     = beat_count(access_size);

    always_ff @(posedge clock) begin
        if (reset_n && w_beat && (w_beat_rw == RW_WRITE) && w_in_range) begin
            r_mem[w_idx] <= data_in;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state    <= c_IDLE;
            r_addr     <= '0;
            r_rw       <= RW_WRITE;
            r_left     <= '0;
            r_err      <= 1'b0;
            r_data_out <= '0;
        end else begin
            r_err <= 1'b0;
            if (w_beat) begin
                r_err  <= ~w_in_range;
                r_addr <= w_beat_addr + ADDRESS_WIDTH'(4);
                if (w_beat_rw == RW_READ) begin
                    r_data_out <= w_in_range ? r_mem[w_idx] : '0;
                end
                if (r_state == c_IDLE) begin
                    r_rw <= rw;
                    if (w_count > 5'd1) begin
                        r_state <= c_BURST;
                        r_left  <= w_count - 5'd1;
                    end
                end else begin
                    r_left <= r_left - 5'd1;
                    if (r_left == 5'd1) begin
                        r_state <= c_IDLE;
                    end
                end
            end else begin
                // Dropping enable mid-burst aborts it without an access.
                r_state <= c_IDLE;
                r_left  <= '0;
            end
        end
    end

    assign busy     = {r_err, (r_state == c_BURST)};
    assign data_out = r_data_out;

endmodule
`default_nettype wire

// File: tb/tb_memory_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_memory_unit
// Description : Directed self-checking bench for memory_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_memory_unit;
    import mem_pkg::*;

    logic        clock;
    logic        reset_n;
    logic [31:0] address;
    logic [31:0] data_in;
    logic [1:0]  access_size;
    logic        rw;
    logic        enable;
    logic [1:0]  busy;
    logic [31:0] data_out;

    int n_vec;
    int n_fail;

    memory_unit dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .address     (address),
        .data_in     (data_in),
        .access_size (access_size),
        .rw          (rw),
        .enable      (enable),
        .busy        (busy),
        .data_out    (data_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wr1(input logic [31:0] a, input logic [31:0] d);
        address = a; data_in = d; rw = RW_WRITE; access_size = ACC_1W; enable = 1'b1;
        tick();
        enable = 1'b0;
    endtask

    task automatic rd1(input string tag, input logic [31:0] a, input logic [31:0] exp);
        address = a; rw = RW_READ; access_size = ACC_1W; enable = 1'b1;
        tick();
        enable = 1'b0;
        check(tag, data_out, exp);
        check({tag, "_busy"}, {30'd0, busy}, 32'd0);
    endtask

    initial begin
        n_vec = 0; n_fail = 0;
        reset_n = 1'b0; address = '0; data_in = '0; access_size = ACC_1W; rw = RW_WRITE; enable = 1'b0;
        tick(); tick();
        check("reset_dout", data_out, 32'd0);
        check("reset_busy", {30'd0, busy}, 32'd0);
        reset_n = 1'b1;

        wr1(32'h8002_0000, 32'h27BD_FFE8);
        rd1("single_rd", 32'h8002_0000, 32'h27BD_FFE8);
        wr1(32'h8002_0004, 32'h1122_3344);
        rd1("unaligned_rd", 32'h8002_0006, 32'h1122_3344);

        for (int k = 0; k < 8; k++) wr1(32'h8002_0000 + 32'(4 * k), 32'(k));
        for (int k = 0; k < 8; k++) rd1($sformatf("preload_%0d", k), 32'h8002_0000 + 32'(4 * k), 32'(k));

        // 4-word write burst; address/rw inputs scrambled after the first beat
        address = 32'h8002_0100; rw = RW_WRITE; access_size = ACC_4W; enable = 1'b1;
        for (int k = 0; k < 4; k++) begin
            data_in = 32'hA0 + 32'(k);
            tick();
            address = 32'hDEAD_BEEF; rw = RW_READ; access_size = ACC_1W;
            check($sformatf("wburst_busy_%0d", k), {30'd0, busy}, (k < 3) ? 32'd1 : 32'd0);
        end
        enable = 1'b0;

        address = 32'h8002_0100; rw = RW_READ; access_size = ACC_4W; enable = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            address = 32'h0000_0000; rw = RW_WRITE;
            check($sformatf("rburst_data_%0d", k), data_out, 32'hA0 + 32'(k));
            check($sformatf("rburst_busy_%0d", k), {30'd0, busy}, (k < 3) ? 32'd1 : 32'd0);
        end
        enable = 1'b0;

        // 16-word read aborted after 5 beats
        address = 32'h8002_0000; rw = RW_READ; access_size = ACC_16W; enable = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            check($sformatf("abort_data_%0d", k), data_out, 32'(k));
        end
        enable = 1'b0;
        tick();
        check("abort_busy", {30'd0, busy}, 32'd0);
        check("abort_hold", data_out, 32'd4);
        rd1("after_abort", 32'h8002_0104, 32'hA1);

        // Out of range read: data_out zero, error pulse for one cycle
        address = 32'h8000_0000; rw = RW_READ; access_size = ACC_1W; enable = 1'b1;
        tick();
        enable = 1'b0;
        check("oor_rd_data", data_out, 32'd0);
        check("oor_rd_busy", {30'd0, busy}, 32'd2);
        tick();
        check("oor_rd_pulse", {30'd0, busy}, 32'd0);

        wr1(32'h8012_0000, 32'hBAD0_BAD0);
        check("oor_wr_busy", {30'd0, busy}, 32'd2);
        rd1("oor_wr_noalias", 32'h8002_0000, 32'd0);

        wr1(32'h8011_FFFC, 32'h5A5A_A5A5);
        rd1("last_word", 32'h8011_FFFC, 32'h5A5A_A5A5);

        // Burst straddling the top of memory: beats 0,1 in range, 2,3 out
        address = 32'h8011_FFF8; rw = RW_READ; access_size = ACC_4W; enable = 1'b1;
        tick();
        tick();
        check("edge_b1_data", data_out, 32'h5A5A_A5A5);
        check("edge_b1_busy", {30'd0, busy}, 32'd1);
        tick();
        check("edge_b2_data", data_out, 32'd0);
        check("edge_b2_busy", {30'd0, busy}, 32'd3);
        tick();
        enable = 1'b0;
        check("edge_b3_busy", {30'd0, busy}, 32'd2);

        // Reset mid-burst returns to idle
        address = 32'h8002_0000; rw = RW_READ; access_size = ACC_8W; enable = 1'b1;
        tick();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1; enable = 1'b0;
        check("rst_burst_busy", {30'd0, busy}, 32'd0);
        check("rst_burst_dout", data_out, 32'd0);
        rd1("post_reset_mem", 32'h8002_001C, 32'd7);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1);
    end

endmodule
`default_nettype wire
